// File: rtl/craps_if.sv
// craps_if: dice/button inputs and game status outputs of the craps controller.
interface craps_if #(parameter int DICE_W = 3) ();
  logic              roll_btn;
  logic              new_game;
  logic [DICE_W-1:0] dice1_in;
  logic [DICE_W-1:0] dice2_in;
  logic [3:0]        sum_out;
  logic [3:0]        point_out;
  logic              point_valid;
  logic              win;
  logic              lose;
  logic              illegal_roll;
  logic [2:0]        state_out;
  logic [7:0]        roll_cnt;
  modport master (
    output roll_btn, new_game, dice1_in, dice2_in,
    input  sum_out, point_out, point_valid, win, lose, illegal_roll, state_out, roll_cnt
  );
  modport slave (
    input  roll_btn, new_game, dice1_in, dice2_in,
    output sum_out, point_out, point_valid, win, lose, illegal_roll, state_out, roll_cnt
  );
endinterface

// File: rtl/craps_game_fsm.sv
// craps_game_fsm: craps rules FSM driven by synchronised roll/new-game buttons.
// Optional accepted-roll counter enabled by defining CRAPS_ROLL_COUNT_EN.
module craps_game_fsm #(
  parameter int DICE_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic   clk,
  input logic   rst,
  craps_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, POINT = 3'd1, WIN = 3'd2, LOSE = 3'd3;
  logic [SYNC_STAGES-1:0] roll_sync, new_sync;
  logic roll_prev, new_prev, roll_p, new_p;
  logic [2:0] state, state_n;
  logic [3:0] sum_q, sum_n, point_q, point_n, sum;
  logic ill_q, ill_n, legal, active, accept;
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      roll_sync <= '0;
      new_sync  <= '0;
      roll_prev <= 1'b0;
      new_prev  <= 1'b0;
    end else begin
      roll_sync <= {roll_sync[SYNC_STAGES-2:0], bus.roll_btn};
      new_sync  <= {new_sync[SYNC_STAGES-2:0], bus.new_game};
      roll_prev <= roll_sync[SYNC_STAGES-1];
      new_prev  <= new_sync[SYNC_STAGES-1];
    end
  assign roll_p = roll_sync[SYNC_STAGES-1] & ~roll_prev;
  assign new_p  = new_sync[SYNC_STAGES-1] & ~new_prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      sum_q   <= '0;
      point_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      state   <= state_n;
      sum_q   <= sum_n;
      point_q <= point_n;
      ill_q   <= ill_n;
    end
  // Rolls only count in IDLE/POINT and only when a restart is not requested the same cycle.
  always_comb begin
    sum    = 4'(bus.dice1_in) + 4'(bus.dice2_in);
    legal  = (bus.dice1_in inside {[1:6]}) && (bus.dice2_in inside {[1:6]});
    active = roll_p && !new_p && (state == IDLE || state == POINT);
    accept = active && legal;
    ill_n  = active && !legal;
    state_n = state;
    if (new_p || state > LOSE)
      state_n = IDLE;
    else if (accept && state == IDLE)
      state_n = (sum == 4'd7 || sum == 4'd11) ? WIN :
                (sum == 4'd2 || sum == 4'd3 || sum == 4'd12) ? LOSE : POINT;
    else if (accept)
      state_n = (sum == point_q) ? WIN : (sum == 4'd7) ? LOSE : POINT;
    sum_n   = new_p ? 4'd0 : accept ? sum : sum_q;
    point_n = new_p ? 4'd0 : (accept && state == IDLE && state_n == POINT) ? sum : point_q;
  end
`ifdef CRAPS_ROLL_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)
      cnt <= '0;
    else
      cnt <= new_p ? 8'd0 : (accept && cnt != 8'hff) ? cnt + 8'd1 : cnt;
`else
  assign cnt = 8'd0;
`endif
  always_comb begin
    bus.state_out    = state;
    bus.sum_out      = sum_q;
    bus.point_out    = point_q;
    bus.point_valid  = state == POINT;
    bus.win          = state == WIN;
    bus.lose         = state == LOSE;
    bus.illegal_roll = ill_q;
    bus.roll_cnt     = cnt;
  end
endmodule

// File: tb/tb_craps_game_fsm.sv
// tb_craps_game_fsm: randomized and directed checks against a rules-level craps model.
module tb_craps_game_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int m_phase, m_point, m_sum, m_cnt;
  craps_if #(.DICE_W(3)) bus ();
  craps_game_fsm #(.DICE_W(3), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [21:0] obs;
  assign obs = {bus.state_out, bus.sum_out, bus.point_out, bus.point_valid, bus.win, bus.lose,
                bus.roll_cnt};
  function automatic logic [21:0] expv();
    int c;
`ifdef CRAPS_ROLL_COUNT_EN
    c = m_cnt;
`else
    c = 0;
`endif
    return {3'(m_phase), 4'(m_sum), 4'(m_point), m_phase == 1, m_phase == 2, m_phase == 3, 8'(c)};
  endfunction
  task automatic model_new();
    m_phase = 0; m_point = 0; m_sum = 0; m_cnt = 0;
  endtask
  // Game rules: phase 0 come-out, 1 point, 2 won, 3 lost.
  task automatic model_roll(input int a, input int b, output int ill);
    int s;
    ill = 0;
    if (m_phase > 1) return;
    if (a < 1 || a > 6 || b < 1 || b > 6) begin ill = 1; return; end
    s = a + b;
    m_sum = s;
    if (m_cnt < 255) m_cnt++;
    if (m_phase == 0) begin
      if (s == 7 || s == 11) m_phase = 2;
      else if (s == 2 || s == 3 || s == 12) m_phase = 3;
      else begin m_point = s; m_phase = 1; end
    end else if (s == m_point) m_phase = 2;
    else if (s == 7) m_phase = 3;
  endtask
  task automatic roll(input int a, input int b, input int hold, output int ill_seen, output int ill_exp);
    bus.dice1_in = 3'(a);
    bus.dice2_in = 3'(b);
    bus.roll_btn = 1'b1;
    ill_seen = 0;
    repeat (hold) begin @(negedge clk); ill_seen += int'(bus.illegal_roll); end
    bus.roll_btn = 1'b0;
    repeat (4) begin @(negedge clk); ill_seen += int'(bus.illegal_roll); end
    model_roll(a, b, ill_exp);
  endtask
  task automatic press_new();
    bus.new_game = 1'b1;
    repeat (5) @(negedge clk);
    bus.new_game = 1'b0;
    repeat (4) @(negedge clk);
    model_new();
  endtask
  task automatic test_reset();
    model_new();
    checks++;
    if (obs !== expv() || bus.illegal_roll !== 1'b0) begin
      errors++; $display("FAIL reset: got %h ill %b want %h ill 0", obs, bus.illegal_roll, expv());
    end
  endtask
  task automatic test_natural();
    int is, ie;
    roll(3, 4, 5, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL natural: got %h want %h", obs, expv()); end
  endtask
  task automatic test_craps();
    int is, ie;
    press_new();
    roll(1, 1, 5, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL craps: got %h want %h", obs, expv()); end
    roll(5, 5, 5, is, ie);
    checks++;
    if (obs !== expv() || is !== 0) begin
      errors++; $display("FAIL terminal_ignore: got %h ill %0d want %h ill 0", obs, is, expv());
    end
    roll(0, 3, 5, is, ie);
    checks++;
    if (is !== 0) begin errors++; $display("FAIL terminal_illegal: got %0d pulses want 0", is); end
  endtask
  task automatic test_point_win();
    int is, ie;
    press_new();
    roll(2, 2, 5, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL point_set: got %h want %h", obs, expv()); end
    roll(5, 1, 5, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL point_stay: got %h want %h", obs, expv()); end
    roll(3, 1, 5, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL point_win: got %h want %h", obs, expv()); end
  endtask
  task automatic test_point_lose();
    int is, ie;
    press_new();
    roll(4, 5, 5, is, ie);
    roll(6, 1, 5, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL point_lose: got %h want %h", obs, expv()); end
    press_new();
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL new_game: got %h want %h", obs, expv()); end
  endtask
  task automatic test_illegal();
    int is, ie;
    press_new();
    roll(3, 3, 5, is, ie);
    roll(0, 3, 5, is, ie);
    checks++;
    if (obs !== expv() || is !== 1) begin
      errors++; $display("FAIL illegal_zero: got %h pulses %0d want %h pulses 1", obs, is, expv());
    end
    roll(2, 7, 5, is, ie);
    checks++;
    if (obs !== expv() || is !== 1) begin
      errors++; $display("FAIL illegal_seven: got %h pulses %0d want %h pulses 1", obs, is, expv());
    end
    press_new();
    roll(2, 2, 20, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL hold_once: got %h want %h", obs, expv()); end
  endtask
  task automatic test_simultaneous();
    press_new();
    begin int is, ie; roll(3, 2, 5, is, ie); end
    bus.dice1_in = 3'd2;
    bus.dice2_in = 3'd2;
    bus.roll_btn = 1'b1;
    bus.new_game = 1'b1;
    repeat (5) @(negedge clk);
    bus.roll_btn = 1'b0;
    bus.new_game = 1'b0;
    repeat (4) @(negedge clk);
    model_new();
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL simultaneous: got %h want %h", obs, expv()); end
  endtask
  task automatic test_saturate();
    int is, ie;
    press_new();
    roll(4, 1, 5, is, ie);
    for (int i = 0; i < 300; i++) roll(3, 3, 4, is, ie);
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL saturate: got %h want %h", obs, expv()); end
  endtask
  task automatic test_random();
    int is, ie, a, b;
    press_new();
    for (int i = 0; i < 200; i++) begin
      if ((m_phase > 1 && $urandom_range(1) == 0) || $urandom_range(14) == 0) press_new();
      else begin
        a = $urandom_range(7);
        b = $urandom_range(7);
        roll(a, b, $urandom_range(8, 4), is, ie);
        checks++;
        if (obs !== expv() || is !== ie) begin
          errors++;
          $display("FAIL random[%0d] %0d+%0d: got %h ill %0d want %h ill %0d", i, a, b, obs, is, expv(), ie);
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    int is, ie;
    press_new();
    roll(5, 5, 5, is, ie);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 model_new();
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL reset_mid: got %h want %h", obs, expv()); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    bus.roll_btn = 1'b0;
    bus.new_game = 1'b0;
    bus.dice1_in = '0;
    bus.dice2_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_natural();
    test_craps();
    test_point_win();
    test_point_lose();
    test_illegal();
    test_simultaneous();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
